floppy_sd_responder: RTL and testbench

Target side of the floppy sector-IO interface. It services per-drive sector read/write requests, each one 512-byte sector addressed by a sector number. It serves each request from a byte-wide image memory (SDRAM/BRAM port with a req/ack handshake) that holds both floppy images. It sits between the floppy track buffer and the memory controller, replacing a real SD card for the floppy path.

---
 rtl/floppy_sd_responder.sv | 168 ++++++++++++++++
 tb/tb_floppy_sd_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floppy_sd_responder.sv
// Floppy sector-IO target: serves 512-byte sector reads/writes for two drives from a
// byte-wide image memory with a req/ack handshake, one memory access per byte.
module floppy_sd_responder #(
    parameter logic [23:0] IMG_BASE0 = 24'h000000,
    parameter logic [23:0] IMG_BASE1 = 24'h0C8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] sd_lba,
    input  logic [1:0]  sd_rd,
    input  logic [1:0]  sd_wr,
    output logic        sd_busy,
    output logic        sd_done,
    output logic [8:0]  sd_addr,
    output logic        sd_data_en,
    output logic [7:0]  sd_data_in,
    input  logic [7:0]  sd_data_out,
    input  logic [31:0] img_size0,
    input  logic [31:0] img_size1,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        range_err
);

    typedef enum logic [2:0] {
        StIdle, StStart, StRdReq, StRdPush, StWrAddr, StWrCap, StWrMem, StDone
    } state_e;

    state_e      r_state, w_state_nxt;
    logic        r_drive, w_drive_nxt;
    logic        r_write, w_write_nxt;
    logic [10:0] r_lba, w_lba_nxt;
    logic        r_oor, w_oor_nxt;
    logic [8:0]  r_addr, w_addr_nxt;
    logic [7:0]  r_rdata, w_rdata_nxt;
    logic [7:0]  r_wdata, w_wdata_nxt;

    logic        w_req;
    logic        w_acc_write;
    logic        w_acc_drive;
    logic [31:0] w_acc_size;
    logic [31:0] w_acc_end;
    logic        w_acc_oor;
    logic        w_last;
    logic [23:0] w_base;
    logic [23:0] w_mem_addr;

    // Writes outrank reads; drive 0 outranks drive 1 within a type.
    assign w_req       = (|sd_rd) | (|sd_wr);
    assign w_acc_write = |sd_wr;
    assign w_acc_drive = w_acc_write ? ~sd_wr[0] : ~sd_rd[0];
    assign w_acc_size  = w_acc_drive ? img_size1 : img_size0;
    assign w_acc_end   = {12'd0, sd_lba, 9'd0} + 32'd512;
    assign w_acc_oor   = w_acc_end > w_acc_size;
    assign w_last      = (r_addr == 9'd511);

    assign w_base     = r_drive ? IMG_BASE1 : IMG_BASE0;
    assign w_mem_addr = w_base + {4'd0, r_lba, 9'd0} + {15'd0, r_addr};

    assign mem_addr   = (mem_rd | mem_wr) ? w_mem_addr : 24'd0;
    assign mem_wdata  = mem_wr ? r_wdata : 8'd0;
    assign sd_addr    = r_addr;
    assign sd_data_in = sd_data_en ? r_rdata : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_drive <= 1'b0;
            r_write <= 1'b0;
            r_lba   <= 11'd0;
            r_oor   <= 1'b0;
            r_addr  <= 9'd0;
            r_rdata <= 8'd0;
            r_wdata <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_drive <= w_drive_nxt;
            r_write <= w_write_nxt;
            r_lba   <= w_lba_nxt;
            r_oor   <= w_oor_nxt;
            r_addr  <= w_addr_nxt;
            r_rdata <= w_rdata_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drive_nxt = r_drive;
        w_write_nxt = r_write;
        w_lba_nxt   = r_lba;
        w_oor_nxt   = r_oor;
        w_addr_nxt  = r_addr;
        w_rdata_nxt = r_rdata;
        w_wdata_nxt = r_wdata;
        sd_busy     = 1'b0;
        sd_done     = 1'b0;
        sd_data_en  = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        range_err   = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_state_nxt = StStart;
                    w_drive_nxt = w_acc_drive;
                    w_write_nxt = w_acc_write;
                    w_lba_nxt   = sd_lba;
                    w_oor_nxt   = w_acc_oor;
                    w_addr_nxt  = 9'd0;
                end
            end
            StStart: begin
                sd_busy     = 1'b1;
                range_err   = r_oor;
                w_state_nxt = r_write ? StWrAddr : StRdReq;
            end
            StRdReq: begin
                sd_busy = 1'b1;
                if (r_oor) begin
                    w_rdata_nxt = 8'h00;
                    w_state_nxt = StRdPush;
                end else begin
                    mem_rd = 1'b1;
                    if (mem_ack) begin
                        w_rdata_nxt = mem_rdata;
                        w_state_nxt = StRdPush;
                    end
                end
            end
            StRdPush: begin
                sd_busy     = 1'b1;
                sd_data_en  = 1'b1;
                // 511 + 1 wraps to 0, which is what DONE presents.
                w_addr_nxt  = r_addr + 9'd1;
                w_state_nxt = w_last ? StDone : StRdReq;
            end
            StWrAddr: begin
                sd_busy     = 1'b1;
                w_state_nxt = StWrCap;
            end
            StWrCap: begin
                sd_busy     = 1'b1;
                w_wdata_nxt = sd_data_out;
                w_state_nxt = StWrMem;
            end
            StWrMem: begin
                sd_busy = 1'b1;
                mem_wr  = ~r_oor;
                if (r_oor || mem_ack) begin
                    w_addr_nxt  = r_addr + 9'd1;
                    w_state_nxt = w_last ? StDone : StWrAddr;
                end
            end
            StDone: begin
                sd_done     = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

endmodule

// File: tb/tb_floppy_sd_responder.sv
// Randomised bench for floppy_sd_responder: a sector-level reference model predicts the
// bytes pushed to the requester and the memory traffic for each transfer.
module tb_floppy_sd_responder;

    localparam logic [23:0] BASE0 = 24'h000000;
    localparam logic [23:0] BASE1 = 24'h0C8000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] sd_lba;
    logic [1:0]  sd_rd;
    logic [1:0]  sd_wr;
    logic        sd_busy;
    logic        sd_done;
    logic [8:0]  sd_addr;
    logic        sd_data_en;
    logic [7:0]  sd_data_in;
    logic [7:0]  sd_data_out;
    logic [31:0] img_size0;
    logic [31:0] img_size1;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        range_err;

    always #5 clk = ~clk;

    floppy_sd_responder #(
        .IMG_BASE0(BASE0),
        .IMG_BASE1(BASE1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sd_lba     (sd_lba),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .sd_busy    (sd_busy),
        .sd_done    (sd_done),
        .sd_addr    (sd_addr),
        .sd_data_en (sd_data_en),
        .sd_data_in (sd_data_in),
        .sd_data_out(sd_data_out),
        .img_size0  (img_size0),
        .img_size1  (img_size1),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .range_err  (range_err)
    );

    typedef struct packed {logic [23:0] a; logic [7:0] d;} mem_t;
    typedef struct packed {logic [8:0] a; logic [7:0] d;} push_t;

    int total = 0;
    int bad   = 0;

    // Written only by the monitor / responder processes; tasks work from base snapshots.
    push_t       push_log[$];
    logic [23:0] rd_log[$];
    mem_t        wr_log[$];
    int          done_cnt = 0;
    int          rerr_cnt = 0;
    int          hold_err = 0;
    logic [7:0]  img [logic [23:0]];

    int push_b, rd_b, wr_b, done_b, rerr_b, hold_b;
    int lat_min = 1;
    int lat_max = 2;
    logic [7:0]  wbuf [512];
    logic [8:0]  req_prev = 9'd0;
    logic [23:0] rsp_a;
    logic [7:0]  rsp_d;
    logic        rsp_w;
    int          rsp_lat;
    int          n;
    bit          rnd_w, rnd_d;
    logic [10:0] rnd_l;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Untouched memory reads back its own low address byte.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (img.exists(a)) return img[a];
        return a[7:0];
    endfunction

    function automatic logic [63:0] outs();
        return {9'd0, sd_busy, sd_done, sd_addr, sd_data_en, sd_data_in, mem_addr,
                mem_rd, mem_wr, mem_wdata, range_err};
    endfunction

    always @(negedge clk) begin
        if (sd_data_en) push_log.push_back({sd_addr, sd_data_in});
        if (sd_done) done_cnt++;
        if (range_err) rerr_cnt++;
    end

    // Requester: presents the buffer byte for the address seen one cycle earlier.
    initial begin
        sd_data_out = 8'd0;
        forever begin
            @(negedge clk);
            sd_data_out = wbuf[req_prev];
            req_prev    = sd_addr;
        end
    end

    // Image memory with random ack latency; checks the request stays steady until ack.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'd0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_rd && mem_wr) hold_err++;
            if (rst_n && (mem_rd || mem_wr)) begin
                rsp_a   = mem_addr;
                rsp_w   = mem_wr;
                rsp_d   = mem_wdata;
                rsp_lat = int'($urandom_range(lat_max, lat_min));
                for (int k = 1; k < rsp_lat; k++) begin
                    @(negedge clk);
                    if (!rst_n) break;
                    if (mem_addr !== rsp_a || mem_wr !== rsp_w || mem_rd !== !rsp_w ||
                        mem_wdata !== rsp_d) hold_err++;
                end
                if (rst_n) begin
                    if (rsp_w) begin
                        img[rsp_a] = rsp_d;
                        wr_log.push_back({rsp_a, rsp_d});
                    end else begin
                        mem_rdata = mem_byte(rsp_a);
                        rd_log.push_back(rsp_a);
                    end
                    mem_ack = 1'b1;
                end
            end
        end
    end

    task automatic mark_logs();
        push_b = push_log.size();
        rd_b   = rd_log.size();
        wr_b   = wr_log.size();
        done_b = done_cnt;
        rerr_b = rerr_cnt;
        hold_b = hold_err;
    endtask

    task automatic issue(input logic [1:0] rd, input logic [1:0] wr, input logic [10:0] lba);
        @(negedge clk);
        mark_logs();
        sd_lba = lba;
        sd_rd  = rd;
        sd_wr  = wr;
    endtask

    task automatic await_busy(input logic [1:0] drop_rd, input logic [1:0] drop_wr,
                              input bit scramble);
        int k = 0;
        while (sd_busy !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_val("busy_rise", sd_busy, 1);
        sd_rd = sd_rd & ~drop_rd;
        sd_wr = sd_wr & ~drop_wr;
        if (scramble) sd_lba = 11'($urandom);
    endtask

    task automatic finish_xfer(input bit wr, input bit drv, input logic [10:0] lba);
        logic [23:0] base;
        logic [31:0] size;
        logic [23:0] ea;
        logic [7:0]  exp_rd [512];
        bit          oor;
        int          k;
        int          b0;
        int          np, nr, nw;
        base = drv ? BASE1 : BASE0;
        size = drv ? img_size1 : img_size0;
        oor  = (longint'(lba) * 512 + 512) > longint'(size);
        for (int i = 0; i < 512; i++) begin
            ea        = base + 24'(lba) * 24'd512 + 24'(i);
            exp_rd[i] = oor ? 8'h00 : mem_byte(ea);
        end
        k = 0;
        while (done_cnt == done_b && k < 15000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_val("done_pulse", done_cnt - done_b, 1);
        check_val("busy_at_done", sd_busy, 0);
        check_val("range_err", rerr_cnt - rerr_b, oor);
        np = push_log.size() - push_b;
        nr = rd_log.size() - rd_b;
        nw = wr_log.size() - wr_b;
        if (!wr) begin
            check_val("rd_push_cnt", np, 512);
            b0 = bad;
            for (int i = 0; i < np && bad == b0; i++) begin
                check_val("rd_push_addr", push_log[push_b + i].a, i);
                check_val("rd_push_data", push_log[push_b + i].d, exp_rd[i]);
            end
            check_val("mem_rd_cnt", nr, oor ? 0 : 512);
            b0 = bad;
            for (int i = 0; i < nr && bad == b0; i++) begin
                ea = base + 24'(lba) * 24'd512 + 24'(i);
                check_val("mem_rd_addr", rd_log[rd_b + i], ea);
            end
            check_val("mem_wr_cnt", nw, 0);
        end else begin
            check_val("wr_push_cnt", np, 0);
            check_val("mem_wr_cnt", nw, oor ? 0 : 512);
            b0 = bad;
            for (int i = 0; i < nw && bad == b0; i++) begin
                ea = base + 24'(lba) * 24'd512 + 24'(i);
                check_val("mem_wr_addr", wr_log[wr_b + i].a, ea);
                check_val("mem_wr_data", wr_log[wr_b + i].d, wbuf[i]);
            end
            check_val("mem_rd_cnt", nr, 0);
        end
        check_val("mem_hold", hold_err - hold_b, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        sd_lba    = 11'd0;
        sd_rd     = 2'b00;
        sd_wr     = 2'b00;
        img_size0 = 32'd819200;
        img_size1 = 32'd819200;
        for (int i = 0; i < 512; i++) wbuf[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1 check_val("reset_outs", outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain read, fixed latency 2.
        lat_min = 2; lat_max = 2;
        issue(2'b01, 2'b00, 11'd3);
        await_busy(2'b01, 2'b00, 1'b1);
        finish_xfer(1'b0, 1'b0, 11'd3);

        // Write drive 1 with inverted-index data.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 512; i++) wbuf[i] = ~8'(i);
        issue(2'b00, 2'b10, 11'd10);
        await_busy(2'b00, 2'b10, 1'b1);
        finish_xfer(1'b1, 1'b1, 11'd10);

        // Concurrent requests: write drive 1 first, then the pending read.
        for (int i = 0; i < 512; i++) wbuf[i] = 8'($urandom);
        issue(2'b01, 2'b10, 11'd20);
        await_busy(2'b00, 2'b10, 1'b0);
        finish_xfer(1'b1, 1'b1, 11'd20);
        mark_logs();
        await_busy(2'b01, 2'b00, 1'b1);
        finish_xfer(1'b0, 1'b0, 11'd20);

        // Range boundaries on a half-size image and an empty drive.
        img_size0 = 32'd409600;
        issue(2'b01, 2'b00, 11'd800);
        await_busy(2'b01, 2'b00, 1'b1);
        finish_xfer(1'b0, 1'b0, 11'd800);
        issue(2'b00, 2'b01, 11'd800);
        await_busy(2'b00, 2'b01, 1'b1);
        finish_xfer(1'b1, 1'b0, 11'd800);
        issue(2'b01, 2'b00, 11'd799);
        await_busy(2'b01, 2'b00, 1'b1);
        finish_xfer(1'b0, 1'b0, 11'd799);
        img_size1 = 32'd0;
        issue(2'b10, 2'b00, 11'd0);
        await_busy(2'b10, 2'b00, 1'b1);
        finish_xfer(1'b0, 1'b1, 11'd0);
        img_size0 = 32'd819200;
        img_size1 = 32'd819200;

        // Asynchronous reset in the middle of a read.
        issue(2'b01, 2'b00, 11'd5);
        await_busy(2'b01, 2'b00, 1'b1);
        n = 0;
        while ((push_log.size() - push_b) < 200 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_val("reached_byte200", (push_log.size() - push_b) >= 200, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_val("async_reset_outs", outs(), 0);
        repeat (3) @(negedge clk);
        check_val("reset_hold_outs", outs(), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("no_done_after_reset", done_cnt - done_b, 0);
        check_val("idle_after_reset", sd_busy, 0);
        issue(2'b01, 2'b00, 11'd6);
        await_busy(2'b01, 2'b00, 1'b1);
        finish_xfer(1'b0, 1'b0, 11'd6);

        // Random transfers with long random ack latency.
        lat_min = 1; lat_max = 20;
        for (int t = 0; t < 3; t++) begin
            rnd_w = (t == 0) ? 1'b0 : 1'($urandom_range(1, 0));
            rnd_d = 1'($urandom_range(1, 0));
            rnd_l = 11'($urandom_range(1700, 0));
            for (int i = 0; i < 512; i++) wbuf[i] = 8'($urandom);
            if (rnd_w) issue(2'b00, rnd_d ? 2'b10 : 2'b01, rnd_l);
            else       issue(rnd_d ? 2'b10 : 2'b01, 2'b00, rnd_l);
            await_busy(2'b11, 2'b11, 1'b1);
            finish_xfer(rnd_w, rnd_d, rnd_l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
